// File: rtl/closest_hit_reduce.sv
// Closest-hit reduction: folds a packet of per-primitive hit results into the nearest
// valid hit (T > T_EPS). It also keeps a saturating beat count and holds the result until consumed.
module closest_hit_reduce #(
  parameter int                 COUNT_W = 8,
  parameter logic signed [31:0] T_EPS   = 32'sd0,
  localparam int                HIT_W   = 123
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [HIT_W-1:0]   in_hit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HIT_W-1:0]   out_hit,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy
);

  // HitData layout carried on in_hit / out_hit; T is signed 16.16 fixed point.
  typedef struct packed {
    logic        bHit;
    logic [31:0] T;
    logic [15:0] PI;
    logic [23:0] color;
    logic [47:0] normal;
    logic [1:0]  surf_type;
  } HitData;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic [1:0]         state;
  HitData             best;
  HitData             in_h;
  logic [COUNT_W-1:0] count;
  logic               accept;
  logic               is_first;
  logic               candidate;
  logic               prior_hit;
  logic               replace;
  logic [COUNT_W-1:0] count_next;

  assign in_h = in_hit;

  // The first beat of a packet compares against an empty best, so nothing leaks between packets.
  always_comb begin
    in_ready   = (state != DONE);
    accept     = in_valid && in_ready;
    is_first   = (state == IDLE);
    candidate  = in_h.bHit && ($signed(in_h.T) > T_EPS);
    prior_hit  = is_first ? 1'b0 : best.bHit;
    replace    = candidate && (!prior_hit || ($signed(in_h.T) < $signed(best.T)));
    count_next = count;
    if (is_first) begin
      count_next = COUNT_W'(1);
    end else if (count != COUNT_MAX) begin
      count_next = count + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      best  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (replace) begin
              best <= in_h;
            end else if (is_first) begin
              best.bHit <= 1'b0;
            end
            count <= count_next;
            state <= in_last ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            best.bHit <= 1'b0;
            count     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_hit   = best;
  assign out_count = count;

endmodule

// File: tb/tb_closest_hit_reduce.sv
// Scoreboard bench for closest_hit_reduce: an 8-bit-counter and a 4-bit-counter instance
// share stimulus; expected results are queued as packets are driven.
module tb_closest_hit_reduce;

  typedef struct packed {
    logic        bHit;
    logic [31:0] T;
    logic [15:0] PI;
    logic [23:0] color;
    logic [47:0] normal;
    logic [1:0]  surf_type;
  } HitData;

  typedef struct {
    HitData hit;
    int     cnt8;
    int     cnt4;
  } exp_t;

  localparam logic signed [31:0] T_EPS = 32'sd0;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  HitData     in_hit = '0;
  logic       in_ready, out_valid, busy;
  logic       in_ready4, out_valid4, busy4;
  HitData     out_hit, out_hit4;
  logic [7:0] out_count;
  logic [3:0] out_count4;

  int     total = 0;
  int     bad = 0;
  HitData pkt [0:31];
  exp_t   exp_q[$];

  always #5 clk = ~clk;

  closest_hit_reduce #(.COUNT_W(8), .T_EPS(T_EPS)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_hit(in_hit), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_count(out_count), .busy(busy)
  );

  closest_hit_reduce #(.COUNT_W(4), .T_EPS(T_EPS)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready4),
    .in_hit(in_hit), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
    .out_hit(out_hit4), .out_count(out_count4), .busy(busy4)
  );

  function automatic HitData mk(input logic b, input int t, input int pi);
    HitData h;
    h.bHit      = b;
    h.T         = 32'(t * 65536);
    h.PI        = 16'(pi);
    h.color     = 24'(pi * 4099 + 7);
    h.normal    = {3{16'(pi + 1)}};
    h.surf_type = 2'(pi);
    return h;
  endfunction

  // Reference model: strict less-than keeps the earliest of equal T values.
  task automatic push_expected(input int n);
    exp_t e;
    e.hit = '0;
    for (int i = 0; i < n; i++) begin
      if (pkt[i].bHit && ($signed(pkt[i].T) > T_EPS) &&
          (!e.hit.bHit || ($signed(pkt[i].T) < $signed(e.hit.T))))
        e.hit = pkt[i];
    end
    e.cnt8 = (n > 255) ? 255 : n;
    e.cnt4 = (n > 15) ? 15 : n;
    exp_q.push_back(e);
  endtask

  task automatic send_packet(input int n);
    push_expected(n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_hit   = pkt[i];
      in_last  = (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010)
      $display("[TB] FAIL reset_flags got=%b want=010", {out_valid, in_ready, busy});
    if ({out_valid, in_ready, busy} !== 3'b010) bad++;
    total++;
    if ({out_hit.bHit, out_count} !== 9'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got bHit=%b count=%0d want 0/0", out_hit.bHit, out_count);
    end
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_closest();
    exp_t e;
    out_ready = 1'b1;
    pkt[0] = mk(1'b1, 5, 11);
    pkt[1] = mk(1'b1, 2, 12);
    pkt[2] = mk(1'b1, 7, 13);
    send_packet(3);
    e = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL closest_latency got out_valid=%b want=1", out_valid);
    end
    total++;
    if (out_hit !== e.hit) begin
      bad++;
      $display("[TB] FAIL closest_hit got=%h want=%h", out_hit, e.hit);
    end
    total++;
    if (out_count !== 8'(e.cnt8)) begin
      bad++;
      $display("[TB] FAIL closest_count got=%0d want=%0d", out_count, e.cnt8);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL closest_one_cycle got=%b want=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_no_hit();
    exp_t e;
    out_ready = 1'b1;
    pkt[0] = mk(1'b0, 3, 21);
    pkt[1] = mk(1'b0, 1, 22);
    pkt[2] = mk(1'b1, 0, 23);
    pkt[3] = mk(1'b1, -2, 24);
    send_packet(4);
    e = exp_q.pop_front();
    total++;
    if ({out_valid, out_hit.bHit} !== {1'b1, e.hit.bHit}) begin
      bad++;
      $display("[TB] FAIL nohit_bhit got valid/bHit=%b%b want=1%b", out_valid, out_hit.bHit, e.hit.bHit);
    end
    total++;
    if (out_count !== 8'(e.cnt8)) begin
      bad++;
      $display("[TB] FAIL nohit_count got=%0d want=%0d", out_count, e.cnt8);
    end
    @(posedge clk); #1;
  endtask

  // A junk beat waits on the input the whole time the result is back-pressured.
  task automatic test_tie_backpressure();
    exp_t e;
    out_ready = 1'b0;
    pkt[0] = mk(1'b1, 3, 1);
    pkt[1] = mk(1'b1, 3, 2);
    send_packet(2);
    e = exp_q.pop_front();
    in_valid = 1'b1;
    in_hit   = mk(1'b1, 1, 99);
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({out_valid, in_ready, out_hit, out_count} !== {1'b1, 1'b0, e.hit, 8'(e.cnt8)}) begin
        bad++;
        $display("[TB] FAIL tie_hold cyc=%0d got v=%b r=%b PI=%0d cnt=%0d want v=1 r=0 PI=%0d cnt=%0d",
                 k, out_valid, in_ready, out_hit.PI, out_count, e.hit.PI, e.cnt8);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready, busy, out_count} !== {3'b010, 8'd0}) begin
      bad++;
      $display("[TB] FAIL tie_handshake got v/r/b=%b cnt=%0d want 010 cnt=0",
               {out_valid, in_ready, busy}, out_count);
    end
    pkt[0] = in_hit;
    push_expected(1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    e = exp_q.pop_front();
    total++;
    if ({out_valid, out_hit, out_count} !== {1'b1, e.hit, 8'(e.cnt8)}) begin
      bad++;
      $display("[TB] FAIL tie_next_packet got v=%b PI=%0d cnt=%0d want v=1 PI=%0d cnt=%0d",
               out_valid, out_hit.PI, out_count, e.hit.PI, e.cnt8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    pkt[0] = mk(1'b1, 1, 10);
    pkt[1] = mk(1'b1, 4, 11);
    send_packet(2);
    in_valid = 1'b1;
    in_hit   = mk(1'b1, 6, 20);
    in_last  = 1'b0;
    e = exp_q.pop_front();
    total++;
    if ({out_valid, in_ready, out_hit} !== {2'b10, e.hit}) begin
      bad++;
      $display("[TB] FAIL b2b_first got v=%b r=%b PI=%0d want v=1 r=0 PI=%0d",
               out_valid, in_ready, out_hit.PI, e.hit.PI);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL b2b_gap got v/r=%b want=01", {out_valid, in_ready});
    end
    pkt[0] = in_hit;
    pkt[1] = mk(1'b1, 8, 21);
    push_expected(2);
    @(posedge clk); #1;
    in_hit  = pkt[1];
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    e = exp_q.pop_front();
    total++;
    if ({out_valid, out_hit, out_count} !== {1'b1, e.hit, 8'(e.cnt8)}) begin
      bad++;
      $display("[TB] FAIL b2b_second got v=%b PI=%0d cnt=%0d want v=1 PI=%0d cnt=%0d",
               out_valid, out_hit.PI, out_count, e.hit.PI, e.cnt8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) pkt[i] = mk(1'b1, 100 - i, 40 + i);
    send_packet(20);
    e = exp_q.pop_front();
    total++;
    if (out_count4 !== 4'(e.cnt4)) begin
      bad++;
      $display("[TB] FAIL sat_count4 got=%0d want=%0d", out_count4, e.cnt4);
    end
    total++;
    if (out_count !== 8'(e.cnt8)) begin
      bad++;
      $display("[TB] FAIL sat_count8 got=%0d want=%0d", out_count, e.cnt8);
    end
    total++;
    if ({out_valid4, out_hit4} !== {1'b1, e.hit}) begin
      bad++;
      $display("[TB] FAIL sat_hit4 got v=%b PI=%0d want v=1 PI=%0d", out_valid4, out_hit4.PI, e.hit.PI);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    exp_t e;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_hit   = mk(1'b1, 1, 30);
    @(posedge clk); #1;
    in_hit   = mk(1'b1, 2, 31);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, in_ready, out_count, out_hit.bHit} !== {3'b001, 8'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rst_accum got v/b/r=%b cnt=%0d bHit=%b want 001/0/0",
               {out_valid, busy, in_ready}, out_count, out_hit.bHit);
    end
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pkt[0] = mk(1'b1, 4, 32);
    send_packet(1);
    e = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_done_setup got out_valid=%b want=1", out_valid);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rst_done got v/b=%b want=00", {out_valid, busy});
    end
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_no_emit got out_valid=%b want=0", out_valid);
    end
    pkt[0] = mk(1'b1, 9, 33);
    send_packet(1);
    e = exp_q.pop_front();
    total++;
    if ({out_valid, out_hit, out_count} !== {1'b1, e.hit, 8'(e.cnt8)}) begin
      bad++;
      $display("[TB] FAIL rst_resume got v=%b T=%h cnt=%0d want v=1 T=%h cnt=%0d",
               out_valid, out_hit.T, out_count, e.hit.T, e.cnt8);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_closest();
    test_no_hit();
    test_tie_backpressure();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
